// File: rtl/sram_1p_march_bist_ctrl_if.sv
// BIST port group between the March C- controller and the single-port SRAM
// macro, plus the controller's start/status handshake.
interface sram_1p_march_bist_ctrl_if #(
  parameter int P_ADDR_WIDTH = 14,
  parameter int P_DATA_WIDTH = 24
);
  logic                    A_START;
  logic [P_DATA_WIDTH-1:0] A_DOUT;
  logic                    A_BIST_EN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic                    A_BUSY;
  logic                    A_DONE;
  logic                    A_FAIL;
  logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR;
  logic [2:0]              A_FAIL_ELEM;

  modport master (
    input  A_START, A_DOUT,
    output A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    output A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    output A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM
  );

  modport slave (
    output A_START, A_DOUT,
    input  A_BIST_EN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    input  A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    input  A_BUSY, A_DONE, A_FAIL, A_FAIL_ADDR, A_FAIL_ELEM
  );
endinterface

// File: rtl/sram_1p_march_bist_ctrl.sv
// March C- BIST controller for the single-port SRAM macro: issues one operation
// per cycle, checks each read one cycle later, records the first miscompare.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | array owned by functional port, waiting for A_START
// S_RUN   | march operations on the BIST port, one per cycle
// S_DRAIN | last read issued, waiting one cycle for its compare
// S_DONE  | result valid, array handed back, A_START restarts
module sram_1p_march_bist_ctrl #(
  parameter int P_ADDR_WIDTH = 14,
  parameter int P_DATA_WIDTH = 24
) (
  input  logic                       A_CLK,
  input  logic                       A_RST,
  sram_1p_march_bist_ctrl_if.master  bist
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX  = {P_ADDR_WIDTH{1'b1}};
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ZERO = {P_ADDR_WIDTH{1'b0}};
  localparam logic [P_DATA_WIDTH-1:0] DATA_ONES = {P_DATA_WIDTH{1'b1}};
  localparam logic [P_DATA_WIDTH-1:0] DATA_ZERO = {P_DATA_WIDTH{1'b0}};

  state_t                    state_q, state_d;
  logic [2:0]                elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                      ph_q, ph_d;
  logic                      en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [P_DATA_WIDTH-1:0]   din_q, din_d, bm_q, bm_d;
  logic                      busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]                fail_elem_q, fail_elem_d;
  logic                      chk_valid_q, chk_valid_d, chk_bg_q, chk_bg_d;
  logic [P_ADDR_WIDTH-1:0]   chk_addr_q, chk_addr_d;
  logic [2:0]                chk_elem_q, chk_elem_d;

  logic [2:0]                nx_elem;
  logic [P_ADDR_WIDTH-1:0]   nx_addr, addr_end;
  logic                      nx_ph, nx_wr, last_op;

  // M3/M4 walk downward; M1..M4 are read-then-write pairs
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic rd_bg(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic wr_bg(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= ADDR_ZERO;
      ph_q        <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= DATA_ZERO;
      bm_q        <= DATA_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_elem_q <= 3'd0;
      chk_valid_q <= 1'b0;
      chk_bg_q    <= 1'b0;
      chk_addr_q  <= ADDR_ZERO;
      chk_elem_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      chk_valid_q <= chk_valid_d;
      chk_bg_q    <= chk_bg_d;
      chk_addr_q  <= chk_addr_d;
      chk_elem_q  <= chk_elem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    en_d        = en_q;
    men_d       = 1'b0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    din_d       = DATA_ZERO;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    chk_valid_d = 1'b0;
    chk_bg_d    = chk_bg_q;
    chk_addr_d  = chk_addr_q;
    chk_elem_d  = chk_elem_q;
    nx_elem     = elem_q;
    nx_addr     = addr_q;
    nx_ph       = 1'b0;
    last_op     = 1'b0;
    addr_end    = elem_down(elem_q) ? ADDR_ZERO : ADDR_MAX;

    // position of the operation following the one now on the bus
    if (elem_two_op(elem_q) && !ph_q) begin
      nx_ph = 1'b1;
    end else if (addr_q == addr_end) begin
      if (elem_q == 3'd5) begin
        last_op = 1'b1;
      end else begin
        nx_elem = elem_q + 3'd1;
        nx_addr = elem_down(nx_elem) ? ADDR_MAX : ADDR_ZERO;
      end
    end else begin
      nx_addr = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end
    nx_wr = (nx_elem == 3'd0) || nx_ph;

    if (chk_valid_q && (bist.A_DOUT != {P_DATA_WIDTH{chk_bg_q}})) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = chk_addr_q;
        fail_elem_d = chk_elem_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist.A_START) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = ADDR_ZERO;
          ph_d        = 1'b0;
          en_d        = 1'b1;
          men_d       = 1'b1;
          wen_d       = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = ADDR_ZERO;
          fail_elem_d = 3'd0;
        end
      end
      S_RUN: begin
        // the read on the bus executes at this edge; its data is checked next cycle
        if (ren_q) begin
          chk_valid_d = 1'b1;
          chk_bg_d    = rd_bg(elem_q);
          chk_addr_d  = addr_q;
          chk_elem_d  = elem_q;
        end
        if (last_op) begin
          state_d = S_DRAIN;
        end else begin
          elem_d = nx_elem;
          addr_d = nx_addr;
          ph_d   = nx_ph;
          men_d  = 1'b1;
          wen_d  = nx_wr;
          ren_d  = !nx_wr;
          din_d  = (nx_wr && wr_bg(nx_elem)) ? DATA_ONES : DATA_ZERO;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        elem_d  = 3'd0;
        addr_d  = ADDR_ZERO;
        ph_d    = 1'b0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    bm_d = men_d ? DATA_ONES : DATA_ZERO;
  end

  assign bist.A_BIST_EN   = en_q;
  assign bist.A_BIST_ADDR = addr_q;
  assign bist.A_BIST_DIN  = din_q;
  assign bist.A_BIST_BM   = bm_q;
  assign bist.A_BIST_MEN  = men_q;
  assign bist.A_BIST_WEN  = wen_q;
  assign bist.A_BIST_REN  = ren_q;
  assign bist.A_BUSY      = busy_q;
  assign bist.A_DONE      = done_q;
  assign bist.A_FAIL      = fail_q;
  assign bist.A_FAIL_ADDR = fail_addr_q;
  assign bist.A_FAIL_ELEM = fail_elem_q;

endmodule
